div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle signed/unsigned integer divider living in the EX stage, directly upstream of the pipeline stall controller. While a divide is in flight, EX raises its stall request from `busy`, freezing PC through EX. When `ready` pulses, EX writes `result` to HI/LO and drops the stall request. Radix-2 restoring algorithm: one quotient bit per cycle, operands latched at start.

## Interface
Parameters:
- `WIDTH`, 32, operand width; `result` is 2*`WIDTH`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `start` in 1: request a divide; held high by EX until `ready` is seen.
- `signed_div` in 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start`.
- `dividend` in `WIDTH`: numerator, sampled with `start` in IDLE.
- `divisor` in `WIDTH`: denominator, sampled with `start` in IDLE.
- `annul` in 1: cancel the in-flight or requested divide (exception/flush).
- `result` out 2*`WIDTH`: {remainder, quotient}; valid only while `ready`=1.
- `ready` out 1: result valid.
- `busy` out 1: high in BYZERO and ON; EX ORs it into its stall request.

## Operation
- States: IDLE, BYZERO, ON, END (encodings shared, see Structure).
- IDLE: if `start`=1 and `annul`=0: divisor==0 -> BYZERO, else -> ON with counter=0. In signed mode, operands are replaced by absolute values and their sign bits are latched. `annul` wins over `start`.
- BYZERO: -> END with result forced to 0 (quotient 0, remainder 0). Same for signed and unsigned.
- ON: each cycle, shift {rem,quo} left by 1, trial-subtract the divisor, and set the quotient bit if non-negative. Counter increments each cycle.
  - On the 32nd iteration (counter == `WIDTH`-1), go to END with sign fix applied to the loaded result:
    - quotient negated if signs differ;
    - remainder takes the dividend's sign.
- END: `ready`=1, `result` held stable. Stay while `start`=1. On `start`=0 -> IDLE, and `ready` and `result` clear.
- `annul`=1 in BYZERO, ON or END -> IDLE next cycle; `ready`=0 and `result`=0 from that edge.
- `start` and operand changes are ignored outside IDLE.
- Arithmetic is modulo 2^`WIDTH`: signed 0x80000000 / -1 gives quotient 0x80000000, remainder 0, with no trap. abs(0x80000000) is treated as an unsigned magnitude.
- Reset values: state IDLE, counter 0, `result` 0, `ready` 0, `busy` 0.

## Timing
- Start accepted at edge t (IDLE, `start`=1):
  - ON for cycles t+1..t+32;
  - END and `ready`=1 from t+33;
  - latency 33 cycles.
- Divide by zero: BYZERO at t+1, END and `ready` at t+2.
- `busy` is combinational from state: 0 in IDLE and END. EX therefore releases its stall in the same cycle `ready` rises, and the pipeline advances on the next edge.
- Back-to-back divides need at least one `start`=0 cycle (END -> IDLE) before a new start.
- Async reset at any state: outputs go to reset values without waiting for a clock edge. The first start is accepted on the first edge after reset deasserts.

## Structure
- Shared defines file: state encodings (`DivFree`, `DivByZero`, `DivOn`, `DivEnd`) and the `DivResultReady`/`DivResultNotReady` and `DivStart`/`DivStop` constants, alongside the existing stall and width macros.
- Single module, no sub-modules. The trial subtractor is an inline `WIDTH`+1-bit subtract.

## Test plan
- Unsigned 100 / 7, start at t: `busy` from t+1, `ready` at t+33 with result = {0x00000002, 0x0000000E}; `busy`=0 at t+33.
- Signed -7 / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2: quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide 0x12345678 / 0, signed and unsigned: `ready` at t+2 with result 0; `busy`=1 only at t+1.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- `annul` pulsed at t+10 mid-ON: IDLE at t+11, `ready` never asserts, `busy`=0 from t+11. A following start computes correctly from fresh operands.
- `reset` asserted low asynchronously at t+20 mid-ON:
  - `busy`, `ready` and `result` are 0 before the next edge;
  - `start` held high at reset release is accepted on the first edge after release.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: state encodings and
// handshake constants used by the divider and its EX-stage consumer.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider, signed and unsigned.
// One quotient bit per cycle; operands latched at start; result is
// {remainder, quotient} and is held while ready is high.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_quo;
    logic             neg_rem;

    // Magnitudes of the incoming operands; the most negative value maps
    // onto itself and is then treated as an unsigned magnitude.
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    assign dvd_abs = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_abs = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;

    // One restoring step: shift {rem,quo} left, trial-subtract at WIDTH+1 bits.
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    always_comb begin
        trial  = {rem_q, quo_q[WIDTH-1]};
        diff   = trial - {1'b0, dvs_q};
        rem_nx = trial[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_nx = diff[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Stall request to EX follows the state directly.
    assign busy = (state == DivByZero) || (state == DivOn);

    // Divider control and datapath with registered result/ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= DivFree;
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
            ready   <= DivResultNotReady;
        end else if (annul && state != DivFree) begin
            state  <= DivFree;
            cnt    <= '0;
            result <= '0;
            ready  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    if (start == DivStart && !annul) begin
                        cnt     <= '0;
                        rem_q   <= '0;
                        quo_q   <= dvd_abs;
                        dvs_q   <= dvs_abs;
                        neg_quo <= signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem <= signed_div && dividend[WIDTH-1];
                        state   <= (divisor == '0) ? DivByZero : DivOn;
                    end
                end
                DivByZero: begin
                    result <= '0;
                    ready  <= DivResultReady;
                    state  <= DivEnd;
                end
                DivOn: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        result <= {neg_rem ? -rem_nx : rem_nx,
                                   neg_quo ? -quo_nx : quo_nx};
                        ready  <= DivResultReady;
                        state  <= DivEnd;
                    end
                end
                DivEnd: begin
                    if (start == DivStop) begin
                        result <= '0;
                        ready  <= DivResultNotReady;
                        cnt    <= '0;
                        state  <= DivFree;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, overflow case, annul and asynchronous reset.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           signed_div = 1'b0;
    logic [W-1:0]   dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           annul = 1'b0;
    logic [2*W-1:0] result;
    logic           ready;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive start at a negedge so edge t accepts it; return in cycle t+1.
    task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Full divide: checks busy, latency in edges after t, result, release.
    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2*W-1:0] exp, input int lat);
        int n;
        launch(sgn, a, b);
        chk({tag, " busy@t+1"}, 64'(busy), 64'd1);
        n = 0;
        while (!ready && n < 100) begin
            if (n > 0) chk({tag, " busy mid"}, 64'(busy), 64'd1);
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " result"}, result, exp);
        chk({tag, " busy@ready"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, " held"}, {result[62:0], ready}, {exp[62:0], 1'b1});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " ready clr"}, 64'(ready), 64'd0);
        chk({tag, " result clr"}, result, 64'd0);
    endtask

    initial begin
        #3;
        chk("reset state", {61'd0, busy, ready, 1'b0} | 64'(result), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_div("u100/7",   1'b0, 32'd100,      32'd7,          {32'h2, 32'hE}, 32);
        run_div("s-7/2",    1'b1, 32'hFFFFFFF9, 32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 32);
        run_div("s7/-2",    1'b1, 32'd7,        32'hFFFFFFFE,   {32'h1, 32'hFFFFFFFD}, 32);
        run_div("s-100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,   {32'hFFFFFFFE, 32'hE}, 32);
        run_div("u/0",      1'b0, 32'h12345678, 32'd0,          64'd0, 1);
        run_div("s/0",      1'b1, 32'h12345678, 32'd0,          64'd0, 1);
        run_div("smin/-1",  1'b1, 32'h80000000, 32'hFFFFFFFF,   {32'h0, 32'h80000000}, 32);
        run_div("umax/1",   1'b0, 32'hFFFFFFFF, 32'd1,          {32'h0, 32'hFFFFFFFF}, 32);
        run_div("umax/16",  1'b0, 32'hFFFFFFFF, 32'h10,         {32'hF, 32'h0FFFFFFF}, 32);
        run_div("u/big",    1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF,   {32'hFFFFFFFE, 32'h0}, 32);

        // Annul mid-divide: edge t+10 returns the unit to IDLE.
        launch(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("annul busy", 64'(busy), 64'd0);
        chk("annul ready", 64'(ready), 64'd0);
        @(negedge clk);
        annul = 1'b0;
        begin
            logic seen = 1'b0;
            repeat (40) begin
                @(posedge clk);
                #1;
                seen = seen | ready | busy;
            end
            chk("annul quiet", 64'(seen), 64'd0);
        end
        run_div("post-annul", 1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 32);

        // Asynchronous reset mid-divide, start held across release.
        launch(1'b0, 32'd50, 32'd5);
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("areset busy", 64'(busy), 64'd0);
        chk("areset ready", 64'(ready), 64'd0);
        chk("areset result", result, 64'd0);
        signed_div = 1'b1;
        dividend   = 32'hFFFFFF38;   // -200
        divisor    = 32'd9;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset busy", 64'(busy), 64'd1);
        begin
            int n = 0;
            while (!ready && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("post-reset latency", 64'(n), 64'd32);
            chk("post-reset result", result, {32'hFFFFFFFE, 32'hFFFFFFEA});
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset clr", 64'(ready), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
